// File: rtl/bcd_ex3_seq.sv
// Multi-digit BCD-to-Excess-3 sequencer: one shared digit converter, LSB digit first.
// Optional macro BCD_EX3_ERR_VEC_EN adds the per-digit error vector port out_err_vec.
module bcd_ex3_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_ex3,
    output logic                  out_err,
`ifdef BCD_EX3_ERR_VEC_EN
    output logic [DIGITS-1:0]     out_err_vec,
`endif
    output logic                  busy
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IDXW-1:0]       idx_r;
    logic [4*DIGITS-1:0]   word_r;
    logic [4*DIGITS-1:0]   ex3_r;
    logic [DIGITS-1:0]     err_vec_r;
    logic [4:0]            conv_s;
    logic                  last_s;

    // Shared digit converter; bit 4 flags a non-BCD digit, whose nibble is forced to 0.
    function automatic logic [4:0] bcd_to_ex3(input logic [3:0] d);
        if (d > 4'd9) begin
            return 5'b1_0000;
        end else begin
            return {1'b0, d + 4'd3};
        end
    endfunction

    assign conv_s = bcd_to_ex3(word_r[idx_r*4 +: 4]);
    assign last_s = (idx_r == IDXW'(DIGITS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; acceptance on either handshake only counts in its own state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CONV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: capture on accept, then one converted nibble per CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r    <= '0;
            idx_r     <= '0;
            ex3_r     <= '0;
            err_vec_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        word_r    <= in_bcd;
                        idx_r     <= '0;
                        ex3_r     <= '0;
                        err_vec_r <= '0;
                    end else begin
                        word_r    <= word_r;
                    end
                end
                CONV: begin
                    ex3_r[idx_r*4 +: 4] <= conv_s[3:0];
                    err_vec_r[idx_r]    <= conv_s[4];
                    if (!last_s) begin
                        idx_r <= idx_r + IDXW'(1);
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Status outputs are straight decodes of the state register.
    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r == CONV);
    assign out_valid = (state_r == DONE);
    assign out_ex3   = ex3_r;
    assign out_err   = |err_vec_r;
`ifdef BCD_EX3_ERR_VEC_EN
    assign out_err_vec = err_vec_r;
`endif

endmodule

// File: tb/tb_bcd_ex3_seq.sv
// Directed self-checking bench for bcd_ex3_seq (DIGITS=4).
module tb_bcd_ex3_seq;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] in_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_ex3;
    logic                out_err;
`ifdef BCD_EX3_ERR_VEC_EN
    logic [DIGITS-1:0]   out_err_vec;
`endif
    logic                busy;

    int n_vec = 0;
    int n_bad = 0;

    bcd_ex3_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ex3   (out_ex3),
        .out_err   (out_err),
`ifdef BCD_EX3_ERR_VEC_EN
        .out_err_vec (out_err_vec),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, follow it through CONV, optionally stall in DONE, then hand it off.
    task automatic run_word(input logic [15:0] w, input logic [15:0] exp_ex3,
                            input logic exp_err, input logic [3:0] exp_vec, input int stall);
        in_bcd    = w;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        chk("in_ready_after_accept", in_ready, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        repeat (DIGITS - 1) begin
            tick();
            chk("busy_conv", busy, 1'b1);
            chk("out_valid_conv", out_valid, 1'b0);
        end
        tick();
        chk("out_valid_done", out_valid, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("in_ready_done", in_ready, 1'b0);
        chk("out_ex3", out_ex3, exp_ex3);
        chk("out_err", out_err, exp_err);
`ifdef BCD_EX3_ERR_VEC_EN
        chk("out_err_vec", out_err_vec, exp_vec);
`else
        chk("out_err_vs_vec", out_err, |exp_vec);
`endif
        repeat (stall) begin
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_ex3", out_ex3, exp_ex3);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("out_valid_after_hs", out_valid, 1'b0);
        chk("in_ready_after_hs", in_ready, 1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_ex3", out_ex3, 16'h0000);
        chk("rst_out_err", out_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1'b1);

        run_word(16'h1234, 16'h4567, 1'b0, 4'b0000, 0);
        run_word(16'h0989, 16'h3CBC, 1'b0, 4'b0000, 0);
        run_word(16'h12A4, 16'h4507, 1'b1, 4'b0010, 0);
        run_word(16'h9999, 16'hCCCC, 1'b0, 4'b0000, 10);
        run_word(16'hF000, 16'h0333, 1'b1, 4'b1000, 0);

        // Reset during CONV: partial result visible, then wiped asynchronously.
        in_bcd   = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("partial_ex3", out_ex3, 16'h00AB);
        chk("partial_busy", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_ex3", out_ex3, 16'h0000);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();
        run_word(16'h0001, 16'h3334, 1'b0, 4'b0000, 0);

        // Back-to-back with in_valid held high: accepts exactly DIGITS+2 cycles apart.
        in_bcd    = 16'h0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_bcd = 16'h9999;
        chk("b2b_first_accept", in_ready, 1'b0);
        repeat (DIGITS) tick();
        chk("b2b_first_valid", out_valid, 1'b1);
        chk("b2b_first_ex3", out_ex3, 16'h3333);
        tick();
        chk("b2b_idle_gap", in_ready, 1'b1);
        chk("b2b_idle_valid", out_valid, 1'b0);
        tick();
        chk("b2b_second_accept", in_ready, 1'b0);
        chk("b2b_second_busy", busy, 1'b1);
        in_valid = 1'b0;
        repeat (DIGITS) tick();
        chk("b2b_second_valid", out_valid, 1'b1);
        chk("b2b_second_ex3", out_ex3, 16'hCCCC);
        chk("b2b_second_err", out_err, 1'b0);
        tick();
        chk("b2b_end_idle", in_ready, 1'b1);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
